// File: rtl/mvm_job_sequencer.sv
// Byte-command front end for the matrix-vector multiplier: parses LOAD_K / RUN_X /
// LOAD_KX_RUN frames, keeps a resident K matrix, issues one {X,K} job and tracks it to completion.
module mvm_job_sequencer #(
  parameter int unsigned R              = 8,
  parameter int unsigned C              = 8,
  parameter int unsigned W_K            = 8,
  parameter int unsigned W_X            = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_byte_tvalid,
  input  logic [7:0]               s_byte_tdata,
  output logic                     s_byte_tready,
  output logic                     m_kx_tvalid,
  input  logic                     m_kx_tready,
  output logic [R*C*W_K+C*W_X-1:0] m_kx_tdata,
  input  logic                     y_tvalid,
  input  logic                     y_tready,
  output logic                     busy,
  output logic                     k_loaded,
  output logic                     err_pulse,
  output logic [7:0]               err_cnt,
  output logic [15:0]              job_cnt
);

  localparam int unsigned KW     = R * C * W_K;
  localparam int unsigned XW     = C * W_X;
  localparam int unsigned BCNT_W = $clog2(R * C + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_K,
    S_RECV_X,
    S_ISSUE,
    S_WAIT_Y
  } state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [XW-1:0]      x_q, x_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               chain_q, chain_d;
  logic               k_loaded_q, k_loaded_d;
  logic [15:0]        job_cnt_q, job_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               err_pulse_q;
  logic               busy_q;
  logic               tready_q;
  logic               tvalid_q;
  logic               err_c;
  logic               byte_acc_c;
  logic               tmo_hit_c;

  assign byte_acc_c = s_byte_tvalid & tready_q;
  assign tmo_hit_c  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Next-state, payload capture and counters
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    x_d        = x_q;
    bcnt_d     = bcnt_q;
    tmo_d      = tmo_q;
    chain_d    = chain_q;
    k_loaded_d = k_loaded_q;
    job_cnt_d  = job_cnt_q;
    err_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (byte_acc_c) begin
          case (s_byte_tdata)
            8'h01: begin state_d = S_RECV_K; chain_d = 1'b0; end
            8'h02: state_d = S_RECV_X;
            8'h03: begin state_d = S_RECV_K; chain_d = 1'b1; end
            default: err_c = 1'b1;
          endcase
        end
      end
      S_RECV_K: begin
        if (byte_acc_c) begin
          for (int unsigned i = 0; i < R * C; i++) begin
            if (bcnt_q == BCNT_W'(i)) k_d[i*W_K +: W_K] = s_byte_tdata;
          end
          tmo_d  = '0;
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(R * C - 1)) begin
            k_loaded_d = 1'b1;
            state_d    = chain_q ? S_RECV_X : S_IDLE;
          end
        end else if (tmo_hit_c) begin
          err_c      = 1'b1;
          k_loaded_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RECV_X: begin
        if (byte_acc_c) begin
          for (int unsigned i = 0; i < C; i++) begin
            if (bcnt_q == BCNT_W'(i)) x_d[i*W_X +: W_X] = s_byte_tdata;
          end
          tmo_d  = '0;
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(C - 1)) begin
            // X without a resident K is consumed in full, then rejected
            if (k_loaded_q) begin
              state_d = S_ISSUE;
            end else begin
              err_c   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end else if (tmo_hit_c) begin
          err_c   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_ISSUE: begin
        if (m_kx_tready) state_d = S_WAIT_Y;
      end
      S_WAIT_Y: begin
        if (y_tvalid && y_tready) begin
          job_cnt_d = job_cnt_q + 16'd1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      bcnt_d = '0;
      tmo_d  = '0;
    end

    err_cnt_d = err_cnt_q;
    if (err_c && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      x_q         <= '0;
      bcnt_q      <= '0;
      tmo_q       <= '0;
      chain_q     <= 1'b0;
      k_loaded_q  <= 1'b0;
      job_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
      tready_q    <= 1'b1;
      tvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      x_q         <= x_d;
      bcnt_q      <= bcnt_d;
      tmo_q       <= tmo_d;
      chain_q     <= chain_d;
      k_loaded_q  <= k_loaded_d;
      job_cnt_q   <= job_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_c;
      busy_q      <= (state_d != S_IDLE);
      tready_q    <= (state_d == S_IDLE) || (state_d == S_RECV_K) || (state_d == S_RECV_X);
      tvalid_q    <= (state_d == S_ISSUE);
    end
  end

  assign s_byte_tready = tready_q;
  assign m_kx_tvalid   = tvalid_q;
  assign m_kx_tdata    = {x_q, k_q};
  assign busy          = busy_q;
  assign k_loaded      = k_loaded_q;
  assign err_pulse     = err_pulse_q;
  assign err_cnt       = err_cnt_q;
  assign job_cnt       = job_cnt_q;

endmodule

// File: tb/tb_mvm_job_sequencer.sv
// Directed bench for mvm_job_sequencer: frame parsing, job issue/stall, result tracking,
// error paths, timeout boundary and asynchronous reset.
module tb_mvm_job_sequencer;

  localparam int unsigned R  = 8;
  localparam int unsigned C  = 8;
  localparam int unsigned DW = R * C * 8 + C * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_byte_tvalid;
  logic [7:0]    s_byte_tdata;
  logic          s_byte_tready;
  logic          m_kx_tvalid;
  logic          m_kx_tready;
  logic [DW-1:0] m_kx_tdata;
  logic          y_tvalid;
  logic          y_tready;
  logic          busy;
  logic          k_loaded;
  logic          err_pulse;
  logic [7:0]    err_cnt;
  logic [15:0]   job_cnt;

  int            tests = 0;
  int            fails = 0;
  logic          seen_v;
  logic [DW-1:0] snap;
  int            n;

  mvm_job_sequencer #(.R(R), .C(C), .W_K(8), .W_X(8), .TIMEOUT_CYCLES(100)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_byte_tvalid (s_byte_tvalid),
    .s_byte_tdata  (s_byte_tdata),
    .s_byte_tready (s_byte_tready),
    .m_kx_tvalid   (m_kx_tvalid),
    .m_kx_tready   (m_kx_tready),
    .m_kx_tdata    (m_kx_tdata),
    .y_tvalid      (y_tvalid),
    .y_tready      (y_tready),
    .busy          (busy),
    .k_loaded      (k_loaded),
    .err_pulse     (err_pulse),
    .err_cnt       (err_cnt),
    .job_cnt       (job_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    s_byte_tvalid = 1'b1;
    s_byte_tdata  = b;
    tick();
    s_byte_tvalid = 1'b0;
    seen_v = seen_v | m_kx_tvalid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; s_byte_tvalid = 1'b0; s_byte_tdata = 8'h00;
    m_kx_tready = 1'b0; y_tvalid = 1'b0; y_tready = 1'b0; seen_v = 1'b0;
    do_reset();

    chk("rst_tready", 32'(s_byte_tready), 32'd1);
    chk("rst_tvalid", 32'(m_kx_tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_kloaded", 32'(k_loaded), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_jobcnt", 32'(job_cnt), 32'd0);
    chk("rst_tdata_lo", 32'(m_kx_tdata[31:0]), 32'd0);

    // LOAD_K with 0x00..0x3F
    send_byte(8'h01);
    chk("loadk_busy", 32'(busy), 32'd1);
    seen_v = 1'b0;
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    chk("loadk_kloaded", 32'(k_loaded), 32'd1);
    chk("loadk_no_valid", 32'(seen_v | m_kx_tvalid), 32'd0);
    chk("loadk_k0", 32'(m_kx_tdata[7:0]), 32'h00);
    chk("loadk_k31", 32'(m_kx_tdata[255:248]), 32'h1F);
    chk("loadk_k63", 32'(m_kx_tdata[511:504]), 32'h3F);
    chk("loadk_idle", 32'(busy), 32'd0);

    // RUN_X 1..8 with MVM stalled
    send_byte(8'h02);
    for (int i = 1; i <= 7; i++) send_byte(8'(i));
    chk("runx_valid_early", 32'(m_kx_tvalid), 32'd0);
    send_byte(8'h08);
    chk("runx_valid_lat1", 32'(m_kx_tvalid), 32'd1);
    chk("runx_x0", 32'(m_kx_tdata[519:512]), 32'h01);
    chk("runx_x7", 32'(m_kx_tdata[575:568]), 32'h08);
    chk("runx_tready_low", 32'(s_byte_tready), 32'd0);
    snap = m_kx_tdata;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_valid", 32'(m_kx_tvalid), 32'd1);
    chk("stall_stable", 32'(m_kx_tdata != snap), 32'd0);
    m_kx_tready = 1'b1;
    tick();
    m_kx_tready = 1'b0;
    chk("hs_valid_drop", 32'(m_kx_tvalid), 32'd0);
    chk("waity_busy", 32'(busy), 32'd1);

    // Byte during WAIT_Y is dropped; result handshake completes the job
    send_byte(8'h01);
    chk("waity_tready", 32'(s_byte_tready), 32'd0);
    chk("waity_jobcnt0", 32'(job_cnt), 32'd0);
    y_tvalid = 1'b1; y_tready = 1'b1;
    tick();
    y_tvalid = 1'b0; y_tready = 1'b0;
    chk("job_done_cnt", 32'(job_cnt), 32'd1);
    chk("job_done_idle", 32'(busy), 32'd0);
    chk("job_done_tready", 32'(s_byte_tready), 32'd1);
    y_tvalid = 1'b1; y_tready = 1'b1;
    tick();
    y_tvalid = 1'b0; y_tready = 1'b0;
    chk("idle_y_ignored", 32'(job_cnt), 32'd1);

    // RUN_X without K, then a bad header
    do_reset();
    seen_v = 1'b0;
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
    chk("nok_errpulse", 32'(err_pulse), 32'd1);
    chk("nok_errcnt", 32'(err_cnt), 32'd1);
    chk("nok_no_valid", 32'(seen_v | m_kx_tvalid), 32'd0);
    chk("nok_idle", 32'(busy), 32'd0);
    tick();
    chk("errpulse_oneshot", 32'(err_pulse), 32'd0);
    send_byte(8'h7E);
    chk("badhdr_errcnt", 32'(err_cnt), 32'd2);
    chk("badhdr_idle", 32'(busy), 32'd0);

    // Byte arriving exactly at timeout expiry wins
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 99; i++) tick();
    send_byte(8'h01);
    chk("tmo_edge_nopulse", 32'(err_pulse), 32'd0);
    chk("tmo_edge_busy", 32'(busy), 32'd1);
    chk("tmo_edge_errcnt", 32'(err_cnt), 32'd2);
    for (int i = 2; i < 64; i++) send_byte(8'(i));
    chk("tmo_edge_kloaded", 32'(k_loaded), 32'd1);

    // LOAD_KX_RUN stalls after 10 K bytes -> timeout
    send_byte(8'h03);
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    n = 0;
    while (n < 200 && !err_pulse) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd100);
    chk("tmo_kloaded", 32'(k_loaded), 32'd0);
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_errcnt", 32'(err_cnt), 32'd3);

    // Full LOAD_KX_RUN job, then a second job reset during ISSUE
    send_byte(8'h03);
    for (int i = 0; i < 64; i++) send_byte(8'(8'h40 + i));
    for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i));
    chk("kx_valid", 32'(m_kx_tvalid), 32'd1);
    chk("kx_k0", 32'(m_kx_tdata[7:0]), 32'h40);
    chk("kx_x0", 32'(m_kx_tdata[519:512]), 32'hC0);
    m_kx_tready = 1'b1;
    tick();
    m_kx_tready = 1'b0;
    y_tvalid = 1'b1; y_tready = 1'b1;
    tick();
    y_tvalid = 1'b0; y_tready = 1'b0;
    chk("kx_jobcnt", 32'(job_cnt), 32'd1);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    chk("issue2_valid", 32'(m_kx_tvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_tvalid", 32'(m_kx_tvalid), 32'd0);
    chk("async_kloaded", 32'(k_loaded), 32'd0);
    chk("async_errcnt", 32'(err_cnt), 32'd0);
    chk("async_jobcnt", 32'(job_cnt), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_tready", 32'(s_byte_tready), 32'd1);
    chk("async_kreg", 32'(m_kx_tdata[7:0]), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // err_cnt saturation
    for (int i = 0; i < 300; i++) send_byte(8'hFF);
    chk("sat_errcnt", 32'(err_cnt), 32'd255);
    chk("sat_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
